// File: rtl/csi_raw10_pkg.sv
// Shared types and helpers for the RAW10 transmit packer.
// The CRC state exists only when CSI_RAW10_CRC_EN is defined.
package csi_raw10_pkg;

    localparam int unsigned BYTES_PERPACK = 5;
    localparam int unsigned PIX_PER_GRP   = 4;

    typedef enum logic [1:0] {
        ST_COLLECT,
        ST_PAD,
`ifdef CSI_RAW10_CRC_EN
        ST_CRC,
`endif
        ST_FLUSH
    } state_t;

    // Reflected CRC-16 (0x8408), one byte, LSB first.
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        c = crc ^ {8'h00, data};
        for (int unsigned i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 16'h8408) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/csi_crc16_5b.sv
// Five chained CRC-16 byte updates for one packed group.
// Compiled only when CSI_RAW10_CRC_EN is defined.
`ifdef CSI_RAW10_CRC_EN
module csi_crc16_5b
    import csi_raw10_pkg::*;
(
    input  logic [15:0]                    crc_in,
    input  logic [BYTES_PERPACK-1:0][7:0]  data,
    output logic [15:0]                    crc_out
);

    always_comb begin
        crc_out = crc_in;
        for (int unsigned i = 0; i < BYTES_PERPACK; i++) begin
            crc_out = crc16_byte(crc_out, data[i]);
        end
    end

endmodule
`endif

// File: rtl/csi_raw10_packer.sv
// RAW10 transmit packer: 4 pixels -> 5 bytes, emitted as little-endian 32-bit words.
// Optional line CRC-16 trailer when CSI_RAW10_CRC_EN is defined.
module csi_raw10_packer
    import csi_raw10_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic [9:0]       pix_i,
    input  logic             pix_valid_i,
    input  logic             pix_last_i,
    output logic             pix_ready_o,
    output logic [31:0]      word_o,
    output logic             word_valid_o,
    input  logic             word_ready_i,
    output logic             word_last_o,
    output logic [2:0]       word_bytes_o,
    output logic [CNT_W-1:0] line_pix_o
);

`ifdef CSI_RAW10_CRC_EN
    localparam state_t ST_POST = ST_CRC;
`else
    localparam state_t ST_POST = ST_FLUSH;
`endif

    state_t                              state, state_nx;
    logic [1:0]                          slot;
    logic [2:0][9:0]                     hold;
    logic [7:0][7:0]                     byte_buf, buf_nx;
    logic [3:0]                          fill, fill_nx;
    logic [CNT_W-1:0]                    pix_cnt, cnt_inc;
    logic [PIX_PER_GRP-1:0][9:0]         grp;
    logic [BYTES_PERPACK-1:0][7:0]       grp_bytes, push_data;
    logic                                accept, pop, grp_push, crc_push;
    int unsigned                         popped, push_n, base;

    assign pix_ready_o  = !wb_rst_i && (state == ST_COLLECT) && ((slot != 2'd3) || (fill <= 4'd3));
    assign accept       = pix_valid_i && pix_ready_o;
    assign word_valid_o = (fill >= 4'd4) || ((state == ST_FLUSH) && (fill != 4'd0));
    assign word_last_o  = (state == ST_FLUSH) && (fill <= 4'd4);
    assign word_bytes_o = word_last_o ? fill[2:0] : 3'd4;
    assign word_o       = byte_buf[3:0];
    assign pop          = word_valid_o && word_ready_i;
    assign cnt_inc      = (pix_cnt == '1) ? pix_cnt : pix_cnt + 1'b1;

    // In PAD the holding regs at or above slot are stale from an earlier line and are masked.
    always_comb begin
        if (state == ST_PAD) begin
            grp[0] = (slot > 2'd0) ? hold[0] : '0;
            grp[1] = (slot > 2'd1) ? hold[1] : '0;
            grp[2] = (slot > 2'd2) ? hold[2] : '0;
            grp[3] = '0;
        end else begin
            grp = {pix_i, hold[2], hold[1], hold[0]};
        end
        for (int unsigned k = 0; k < PIX_PER_GRP; k++) begin
            grp_bytes[2'(k)] = grp[2'(k)][9:2];
        end
        grp_bytes[4] = {grp[3][1:0], grp[2][1:0], grp[1][1:0], grp[0][1:0]};
    end

    always_comb begin
        state_nx = state;
        grp_push = 1'b0;
        crc_push = 1'b0;
        case (state)
            ST_COLLECT: begin
                if (accept) begin
                    if (slot == 2'd3) begin
                        grp_push = 1'b1;
                        if (pix_last_i) state_nx = ST_POST;
                    end else if (pix_last_i) begin
                        state_nx = ST_PAD;
                    end
                end
            end
            ST_PAD: begin
                if (fill <= 4'd3) begin
                    grp_push = 1'b1;
                    state_nx = ST_POST;
                end
            end
`ifdef CSI_RAW10_CRC_EN
            ST_CRC: begin
                if (fill <= 4'd6) begin
                    crc_push = 1'b1;
                    state_nx = ST_FLUSH;
                end
            end
`endif
            ST_FLUSH: begin
                if ((pop && word_last_o) || (fill == 4'd0)) state_nx = ST_COLLECT;
            end
            default: state_nx = ST_COLLECT;
        endcase
    end

`ifdef CSI_RAW10_CRC_EN
    logic [15:0] crc_q, crc_grp;

    csi_crc16_5b u_crc (
        .crc_in  (crc_q),
        .data    (grp_bytes),
        .crc_out (crc_grp)
    );

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            crc_q <= 16'hFFFF;
        end else if (state == ST_FLUSH && state_nx == ST_COLLECT) begin
            crc_q <= 16'hFFFF;
        end else if (grp_push) begin
            crc_q <= crc_grp;
        end
    end
`endif

    // Pop shifts the buffer down first; pushed bytes land just above what remains.
    always_comb begin
        popped = 0;
        if (pop) popped = (fill >= 4'd4) ? 4 : 32'(fill);
        push_n = grp_push ? BYTES_PERPACK : (crc_push ? 2 : 0);
        push_data = grp_bytes;
`ifdef CSI_RAW10_CRC_EN
        if (crc_push) begin
            push_data    = '0;
            push_data[0] = crc_q[7:0];
            push_data[1] = crc_q[15:8];
        end
`endif
        base = 32'(fill) - popped;
        for (int unsigned i = 0; i < 8; i++) begin
            int unsigned idx;
            idx = i + popped;
            buf_nx[3'(i)] = (idx < 8) ? byte_buf[idx[2:0]] : '0;
            if (i >= base && i < base + push_n) buf_nx[3'(i)] = push_data[3'(i - base)];
        end
        fill_nx = 4'(base + push_n);
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state      <= ST_COLLECT;
            slot       <= '0;
            hold       <= '0;
            byte_buf   <= '0;
            fill       <= '0;
            pix_cnt    <= '0;
            line_pix_o <= '0;
        end else begin
            state    <= state_nx;
            byte_buf <= buf_nx;
            fill     <= fill_nx;
            if (accept) begin
                if (slot != 2'd3) hold[slot] <= pix_i;
                slot <= slot + 2'd1;
                if (pix_last_i) begin
                    line_pix_o <= cnt_inc;
                    pix_cnt    <= '0;
                end else begin
                    pix_cnt <= cnt_inc;
                end
            end
            if (state == ST_FLUSH && state_nx == ST_COLLECT) slot <= '0;
        end
    end

endmodule

// File: tb/tb_csi_raw10_packer.sv
// Directed + randomized bench for csi_raw10_packer against a byte-stream reference model.
// Define CSI_RAW10_CRC_EN for both RTL and bench to cover the CRC trailer.
module tb_csi_raw10_packer;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i;
    logic [9:0]  pix_i;
    logic        pix_valid_i;
    logic        pix_last_i;
    logic        pix_ready_o;
    logic [31:0] word_o;
    logic        word_valid_o;
    logic        word_ready_i;
    logic        word_last_o;
    logic [2:0]  word_bytes_o;
    logic [15:0] line_pix_o;

    int vectors = 0;
    int miscompares = 0;

    logic [9:0] pix_arr[$];
    logic [7:0] exp_bytes[$];

    always #5 wb_clk_i = ~wb_clk_i;

    csi_raw10_packer #(.CNT_W(16)) dut (
        .wb_clk_i     (wb_clk_i),
        .wb_rst_i     (wb_rst_i),
        .pix_i        (pix_i),
        .pix_valid_i  (pix_valid_i),
        .pix_last_i   (pix_last_i),
        .pix_ready_o  (pix_ready_o),
        .word_o       (word_o),
        .word_valid_o (word_valid_o),
        .word_ready_i (word_ready_i),
        .word_last_o  (word_last_o),
        .word_bytes_o (word_bytes_o),
        .line_pix_o   (line_pix_o)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Reference: zero-pad to whole groups, 4 high bytes then one low-bit byte, optional CRC trailer.
    task automatic make_expected();
        int n, ng;
        int p[4];
        n  = pix_arr.size();
        ng = (n + 3) / 4;
        exp_bytes.delete();
        for (int g = 0; g < ng; g++) begin
            for (int k = 0; k < 4; k++) p[k] = (4 * g + k < n) ? int'(pix_arr[4 * g + k]) : 0;
            for (int k = 0; k < 4; k++) exp_bytes.push_back(8'(p[k] / 4));
            exp_bytes.push_back(8'((p[0] % 4) + (p[1] % 4) * 4 + (p[2] % 4) * 16 + (p[3] % 4) * 64));
        end
`ifdef CSI_RAW10_CRC_EN
        begin
            logic [15:0] crc;
            logic [7:0]  b;
            logic        fb;
            crc = 16'hFFFF;
            foreach (exp_bytes[i]) begin
                b = exp_bytes[i];
                for (int j = 0; j < 8; j++) begin
                    fb  = crc[0] ^ b[j];
                    crc = crc >> 1;
                    if (fb) crc = crc ^ 16'h8408;
                end
            end
            exp_bytes.push_back(crc[7:0]);
            exp_bytes.push_back(crc[15:8]);
        end
`endif
    endtask

    // mode 0: all valid, ready=1; mode 1: random bubbles and backpressure; mode 2: stall after 8 pixels
    task automatic run_line(input int mode);
        int n, sent, nwords, got, cyc, stall, acc4, rem, nb;
        bit ready_low, stall_chk;
        logic [31:0] w;
        n = pix_arr.size();
        make_expected();
        nwords = (exp_bytes.size() + 3) / 4;
        sent = 0; got = 0; cyc = 0; stall = 0; acc4 = -10;
        ready_low = 0; stall_chk = 0;
        while (got < nwords && cyc < 2000) begin
            @(negedge wb_clk_i);
            cyc++;
            if (sent < n && (mode != 1 || $urandom_range(3) != 0)) begin
                pix_valid_i = 1'b1;
                pix_i       = pix_arr[sent];
                pix_last_i  = (sent == n - 1);
            end else begin
                pix_valid_i = 1'b0;
                pix_last_i  = 1'b0;
                pix_i       = 10'($urandom_range(1023));
            end
            case (mode)
                1: word_ready_i = 1'($urandom_range(1));
                2: begin
                    if (sent >= 8 && stall < 10) begin
                        word_ready_i = 1'b0;
                        stall++;
                    end else begin
                        word_ready_i = 1'b1;
                    end
                end
                default: word_ready_i = 1'b1;
            endcase
            #3;
            if (cyc == acc4 + 1) check("latency_valid", 32'(word_valid_o), 32'd1);
            if (mode == 2 && stall == 10 && !stall_chk) begin
                stall_chk = 1;
                check("stall_pix_ready", 32'(pix_ready_o), 32'd0);
            end
            if (mode == 0 && pix_valid_i && !pix_ready_o) ready_low = 1;
            if (pix_valid_i && pix_ready_o) begin
                if (sent == 3) acc4 = cyc;
                sent++;
            end
            if (word_valid_o && word_ready_i) begin
                rem = exp_bytes.size() - 4 * got;
                nb  = (rem < 4) ? rem : 4;
                w   = '0;
                for (int j = 0; j < nb; j++) w[8 * j +: 8] = exp_bytes[4 * got + j];
                check("word", word_o, w);
                check("word_bytes", 32'(word_bytes_o), 32'(nb));
                check("word_last", 32'(word_last_o), 32'(rem <= 4));
                got++;
            end
        end
        pix_valid_i  = 1'b0;
        pix_last_i   = 1'b0;
        word_ready_i = 1'b1;
        check("words_seen", 32'(got), 32'(nwords));
        check("pix_sent", 32'(sent), 32'(n));
        @(negedge wb_clk_i);
        #3;
        check("line_pix", 32'(line_pix_o), 32'(n));
        check("idle_after_line", 32'(word_valid_o), 32'd0);
        if (mode == 0) check("ready_never_low", 32'(ready_low), 32'd0);
    endtask

    initial begin
        wb_rst_i = 1'b1; pix_i = '0; pix_valid_i = 1'b0; pix_last_i = 1'b0; word_ready_i = 1'b1;
        repeat (3) @(negedge wb_clk_i);
        #3;
        check("rst_pix_ready", 32'(pix_ready_o), 32'd0);
        check("rst_word_valid", 32'(word_valid_o), 32'd0);
        check("rst_word_last", 32'(word_last_o), 32'd0);
        check("rst_word_bytes", 32'(word_bytes_o), 32'd4);
        check("rst_word", word_o, 32'd0);
        check("rst_line_pix", 32'(line_pix_o), 32'd0);
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        #3;
        check("post_rst_pix_ready", 32'(pix_ready_o), 32'd1);

        // Basic 4-pixel line
        pix_arr = '{10'h3FD, 10'h002, 10'h003, 10'h00A};
        run_line(0);

        // 16 pixels back-to-back
        pix_arr.delete();
        for (int i = 0; i < 16; i++) pix_arr.push_back(10'($urandom_range(1023)));
        run_line(0);

        // Backpressure after 8 pixels
        pix_arr.delete();
        for (int i = 0; i < 20; i++) pix_arr.push_back(10'($urandom_range(1023)));
        run_line(2);

        // 6 pixels: padded group
        pix_arr.delete();
        for (int i = 0; i < 6; i++) pix_arr.push_back(10'($urandom_range(1023)));
        run_line(0);

        // Reset after 2 accepted pixels discards the partial line
        @(negedge wb_clk_i);
        pix_valid_i = 1'b1; pix_i = 10'h155; pix_last_i = 1'b0;
        @(negedge wb_clk_i);
        pix_i = 10'h2AA;
        @(negedge wb_clk_i);
        pix_valid_i = 1'b0;
        wb_rst_i = 1'b1;
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        #3;
        check("midrst_word_valid", 32'(word_valid_o), 32'd0);
        check("midrst_line_pix", 32'(line_pix_o), 32'd0);
        check("midrst_pix_ready", 32'(pix_ready_o), 32'd1);
        pix_arr = '{10'h0FF, 10'h301, 10'h012, 10'h3C7, 10'h080};
        run_line(0);

        // Single-pixel line and random lines with bubbles/backpressure
        pix_arr = '{10'h3FF};
        run_line(1);
        for (int l = 0; l < 8; l++) begin
            pix_arr.delete();
            for (int i = 0, len = $urandom_range(23, 1); i < len; i++) pix_arr.push_back(10'($urandom_range(1023)));
            run_line(1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
